// File: rtl/crono_regresivo.sv
// Countdown timer for the VGA display: holds HH:MM:SS in packed BCD and counts it
// down one second every DIV clocks, raising crono_final when it reaches 00:00:00.
module crono_regresivo #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       reloj_nexys,
  input  logic       reset_total,
  input  logic       carga,
  input  logic [7:0] hora_ini,
  input  logic [7:0] min_ini,
  input  logic [7:0] seg_ini,
  input  logic       inicio,
  input  logic       pausa,
  input  logic       apagar,
  output logic [7:0] hora_crono,
  output logic [7:0] min_crono,
  output logic [7:0] seg_crono,
  output logic       crono_final,
  output logic       activo
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    hora_dec_s;
  logic [7:0]    min_dec_s;
  logic [7:0]    seg_dec_s;
  logic [8:0]    seg_step_s;
  logic [8:0]    min_step_s;
  logic          cur_zero_s;
  logic          dec_zero_s;

  // Out-of-range or non-BCD fields are replaced by 00 on load.
  function automatic logic [7:0] load_field(input logic [7:0] v, input logic [7:0] max_v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_v) begin
      load_field = 8'h00;
    end else begin
      load_field = v;
    end
  endfunction

  // Minutes/seconds step: returns {borrow_out, new_value}, 00 wraps to 59.
  function automatic logic [8:0] dec_base60(input logic [7:0] v);
    if (v[3:0] != 4'd0) begin
      dec_base60 = {1'b0, v[7:4], v[3:0] - 4'd1};
    end else if (v[7:4] != 4'd0) begin
      dec_base60 = {1'b0, v[7:4] - 4'd1, 4'd9};
    end else begin
      dec_base60 = {1'b1, 8'h59};
    end
  endfunction

  function automatic logic [7:0] dec_hours(input logic [7:0] v);
    if (v[3:0] != 4'd0) begin
      dec_hours = {v[7:4], v[3:0] - 4'd1};
    end else if (v[7:4] != 4'd0) begin
      dec_hours = {v[7:4] - 4'd1, 4'd9};
    end else begin
      dec_hours = 8'h00;
    end
  endfunction

  // Next value one second down, with the BCD borrow rippling seconds -> minutes -> hours.
  always_comb begin
    seg_step_s = dec_base60(seg_crono);
    min_step_s = {1'b0, min_crono};
    hora_dec_s = hora_crono;
    if (seg_step_s[8]) begin
      min_step_s = dec_base60(min_crono);
    end else begin
      min_step_s = {1'b0, min_crono};
    end
    if (min_step_s[8]) begin
      hora_dec_s = dec_hours(hora_crono);
    end else begin
      hora_dec_s = hora_crono;
    end
    seg_dec_s  = seg_step_s[7:0];
    min_dec_s  = min_step_s[7:0];
    cur_zero_s = ({hora_crono, min_crono, seg_crono} == 24'h000000);
    dec_zero_s = ({hora_dec_s, min_dec_s, seg_dec_s} == 24'h000000);
  end

  // Control FSM, prescaler and registered outputs; carga > apagar > pausa > inicio.
  always_ff @(posedge reloj_nexys or posedge reset_total) begin
    if (reset_total) begin
      state_r     <= IDLE;
      presc_r     <= '0;
      hora_crono  <= 8'h00;
      min_crono   <= 8'h00;
      seg_crono   <= 8'h00;
      crono_final <= 1'b0;
      activo      <= 1'b0;
    end else if (carga) begin
      state_r     <= IDLE;
      presc_r     <= '0;
      hora_crono  <= load_field(hora_ini, 8'h23);
      min_crono   <= load_field(min_ini, 8'h59);
      seg_crono   <= load_field(seg_ini, 8'h59);
      crono_final <= 1'b0;
      activo      <= 1'b0;
    end else if (apagar) begin
      state_r     <= IDLE;
      presc_r     <= '0;
      hora_crono  <= 8'h00;
      min_crono   <= 8'h00;
      seg_crono   <= 8'h00;
      crono_final <= 1'b0;
      activo      <= 1'b0;
    end else if (pausa && state_r == RUN) begin
      // Prescaler is frozen so the partial second survives the pause.
      state_r <= PAUSE;
      activo  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, PAUSE: begin
          if (inicio && !cur_zero_s) begin
            state_r <= RUN;
            activo  <= 1'b1;
          end else begin
            state_r <= state_r;
            activo  <= 1'b0;
          end
        end
        RUN: begin
          if (presc_r == LAST) begin
            presc_r    <= '0;
            hora_crono <= hora_dec_s;
            min_crono  <= min_dec_s;
            seg_crono  <= seg_dec_s;
            if (dec_zero_s) begin
              state_r     <= DONE;
              crono_final <= 1'b1;
              activo      <= 1'b0;
            end else begin
              state_r <= RUN;
              activo  <= 1'b1;
            end
          end else begin
            presc_r <= presc_r + PW'(1);
          end
        end
        DONE: begin
          state_r     <= DONE;
          crono_final <= 1'b1;
          activo      <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          presc_r <= '0;
          activo  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crono_regresivo.sv
// Bench for crono_regresivo: directed scenarios plus random commands, all checked
// against a model that keeps the countdown as a plain number of seconds.
module tb_crono_regresivo;

  localparam int DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       reset_total;
  logic       carga, inicio, pausa, apagar;
  logic [7:0] hora_ini, min_ini, seg_ini;
  logic [7:0] hora_crono, min_crono, seg_crono;
  logic       crono_final, activo;

  int n_assert = 0;
  int n_fail   = 0;

  int m_secs, m_presc, m_state;
  bit m_done;

  crono_regresivo #(.DIV(DIV)) dut (
    .reloj_nexys(clk),
    .reset_total(reset_total),
    .carga(carga),
    .hora_ini(hora_ini),
    .min_ini(min_ini),
    .seg_ini(seg_ini),
    .inicio(inicio),
    .pausa(pausa),
    .apagar(apagar),
    .hora_crono(hora_crono),
    .min_crono(min_crono),
    .seg_crono(seg_crono),
    .crono_final(crono_final),
    .activo(activo)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int field_val(input logic [7:0] b, input int max_v);
    int t, u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9 || t * 10 + u > max_v) return 0;
    return t * 10 + u;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_state = S_IDLE; m_done = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs sampled at that edge.
  task automatic model_edge(input logic c, input logic a, input logic p, input logic i);
    if (c) begin
      m_secs = field_val(hora_ini, 23) * 3600 + field_val(min_ini, 59) * 60 + field_val(seg_ini, 59);
      m_done = 1'b0; m_presc = 0; m_state = S_IDLE;
    end else if (a) begin
      m_secs = 0; m_done = 1'b0; m_presc = 0; m_state = S_IDLE;
    end else if (p && m_state == S_RUN) begin
      m_state = S_PAUSE;
    end else if (m_state == S_RUN) begin
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_secs  = m_secs - 1;
        if (m_secs == 0) begin
          m_done = 1'b1; m_state = S_DONE;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end else if ((m_state == S_IDLE || m_state == S_PAUSE) && i && m_secs != 0) begin
      m_state = S_RUN;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".hora"}, hora_crono, to_bcd(m_secs / 3600));
    chk({tag, ".min"}, min_crono, to_bcd((m_secs / 60) % 60));
    chk({tag, ".seg"}, seg_crono, to_bcd(m_secs % 60));
    chk({tag, ".final"}, {7'd0, crono_final}, {7'd0, m_done});
    chk({tag, ".activo"}, {7'd0, activo}, {7'd0, (m_state == S_RUN)});
  endtask

  task automatic tick(input string tag, input logic c, input logic a, input logic p, input logic i);
    carga = c; apagar = a; pausa = p; inicio = i;
    @(posedge clk);
    model_edge(c, a, p, i);
    #1;
    carga = 1'b0; apagar = 1'b0; pausa = 1'b0; inicio = 1'b0;
    check_model(tag);
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hora_ini = h; min_ini = m; seg_ini = s;
    tick("load", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick("run", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_val(input string tag, input logic [23:0] exp_v);
    chk({tag, ".hora"}, hora_crono, exp_v[23:16]);
    chk({tag, ".min"}, min_crono, exp_v[15:8]);
    chk({tag, ".seg"}, seg_crono, exp_v[7:0]);
  endtask

  initial begin
    logic c, a, p, i;
    reset_total = 1'b1;
    carga = 1'b0; inicio = 1'b0; pausa = 1'b0; apagar = 1'b0;
    hora_ini = 8'h00; min_ini = 8'h00; seg_ini = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_val("reset", 24'h000000);
    chk("reset.final", {7'd0, crono_final}, 8'h00);
    chk("reset.activo", {7'd0, activo}, 8'h00);
    reset_total = 1'b0;

    // Asynchronous reset in the middle of a running count.
    load(8'h00, 8'h00, 8'h30);
    tick("start", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(5);
    #2 reset_total = 1'b1;
    #1;
    chk_val("async_rst", 24'h000000);
    chk("async_rst.activo", {7'd0, activo}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    chk_val("rst_hold", 24'h000000);
    #2 reset_total = 1'b0;
    tick("inicio_after_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("inicio_after_rst.activo", {7'd0, activo}, 8'h00);

    // Load and count: 00:01:01 -> 00:01:00 -> 00:00:59.
    load(8'h00, 8'h01, 8'h01);
    tick("start", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("count.activo", {7'd0, activo}, 8'h01);
    idle_ticks(3);
    chk_val("count.before_step", 24'h000101);
    idle_ticks(1);
    chk_val("count.step1", 24'h000100);
    idle_ticks(4);
    chk_val("count.step2", 24'h000059);

    // Borrow chains.
    load(8'h01, 8'h00, 8'h00);
    tick("start", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(4);
    chk_val("borrow_hour", 24'h005959);
    load(8'h10, 8'h00, 8'h00);
    tick("start", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(4);
    chk_val("borrow_tens", 24'h095959);

    // Completion, inicio ignored in DONE, apagar clears.
    load(8'h00, 8'h00, 8'h02);
    tick("start", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(8);
    chk_val("done", 24'h000000);
    chk("done.final", {7'd0, crono_final}, 8'h01);
    chk("done.activo", {7'd0, activo}, 8'h00);
    tick("done_inicio", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("done_inicio.final", {7'd0, crono_final}, 8'h01);
    tick("apagar", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("apagar.final", {7'd0, crono_final}, 8'h00);

    // Pause two cycles into a step, then pause on the decrement cycle.
    load(8'h00, 8'h05, 8'h00);
    tick("start", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(2);
    tick("pause", 1'b0, 1'b0, 1'b1, 1'b0);
    idle_ticks(10);
    chk_val("paused", 24'h000500);
    tick("resume", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume.activo", {7'd0, activo}, 8'h01);
    idle_ticks(1);
    chk_val("resume.wait", 24'h000500);
    idle_ticks(1);
    chk_val("resume.step", 24'h000459);
    idle_ticks(3);
    tick("pause_last", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_val("pause_last", 24'h000459);
    tick("resume2", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(1);
    chk_val("resume2.step", 24'h000458);

    // Field validation and command priority.
    load(8'h24, 8'h5A, 8'h30);
    chk_val("validate", 24'h000030);
    hora_ini = 8'h00; min_ini = 8'h00; seg_ini = 8'h07;
    tick("carga_inicio", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("carga_inicio.activo", {7'd0, activo}, 8'h00);
    chk_val("carga_inicio", 24'h000007);
    tick("clear", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("inicio_zero", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("inicio_zero.activo", {7'd0, activo}, 8'h00);

    // Random command stream against the model.
    for (int n = 0; n < 800; n++) begin
      c = ($urandom_range(39) == 0);
      a = ($urandom_range(59) == 0);
      p = ($urandom_range(9) == 0);
      i = ($urandom_range(5) == 0);
      if (c) begin
        hora_ini = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'h00;
        min_ini  = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : to_bcd(int'($urandom_range(1)));
        seg_ini  = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : to_bcd(int'($urandom_range(59)));
      end
      tick("rand", c, a, p, i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/crono_regresivo.md
# crono_regresivo

Countdown-timer stage that feeds the VGA display controller: holds a user-programmed hours/minutes/seconds value in packed BCD, counts it down once per second from the 100 MHz board clock, and drives `hora_crono`, `min_crono`, `seg_crono` and the `crono_final` alarm flag consumed by the display. It sits between the programming/keypad logic, which supplies the load values and commands, and the display controller.

## Interface

Parameters:
- `DIV`, 100000000: clock cycles per countdown step (1 s at 100 MHz). Benches override to a small value; must be ≥2.

Ports:
- `reloj_nexys`  in  1  system clock, rising-edge.
- `reset_total`  in  1  asynchronous, active-high reset.
- `carga`  in  1  load pulse: capture `hora_ini`/`min_ini`/`seg_ini`.
- `hora_ini`  in  8  initial hours, packed BCD, 00–23.
- `min_ini`  in  8  initial minutes, packed BCD, 00–59.
- `seg_ini`  in  8  initial seconds, packed BCD, 00–59.
- `inicio`  in  1  start/resume command.
- `pausa`  in  1  pause command.
- `apagar`  in  1  alarm acknowledge / clear.
- `hora_crono`  out  8  current hours, packed BCD.
- `min_crono`  out  8  current minutes, packed BCD.
- `seg_crono`  out  8  current seconds, packed BCD.
- `crono_final`  out  1  high when the countdown has reached 00:00:00.
- `activo`  out  1  high while in state RUN.

## Operation

- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- Reset: all outputs 0, prescaler 0, state IDLE.
- Command priority when several are high in one cycle: `carga` > `apagar` > `pausa` > `inicio`. Commands are level-sampled every cycle; callers pulse them for one cycle.
- `carga`, in any state: registers the three fields, clears `crono_final`, prescaler → 0, state → IDLE.
  - Field validation is per field. A field with any nibble >9, hours >0x23, or min/seg >0x59 loads as 0x00. Other fields load normally.
- `apagar`: clears `crono_final`, zeroes all three outputs, prescaler → 0, state → IDLE.
- `inicio`:
  - IDLE or PAUSE → RUN if the value ≠ 00:00:00.
  - If the value is zero, stay IDLE.
  - Ignored in RUN and DONE.
- `pausa`: RUN → PAUSE. The prescaler value is retained; no decrement occurs in that cycle. Ignored in other states.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - In the cycle the prescaler equals DIV-1, the value decrements by one second.
- Decrement rule (BCD borrow chain):
  - `seg` units 0 → 9 with borrow from `seg` tens.
  - `seg` tens 0 → 5 with borrow from `min`.
  - `min` follows the same rule, with borrow from `hora`.
  - `hora` units 0 → 9 with borrow from `hora` tens.
  - No hour wrap is needed because RUN is never entered at zero.
- A decrement that produces 00:00:00 sets `crono_final` = 1 and state → DONE in the same edge.
- DONE: value held at zero, `crono_final` held high until `carga` or `apagar`.
- `activo` = (state == RUN), registered.

## Timing

- All outputs are registered. Command effects are visible one clock after the sampling edge.
- `inicio` at edge k:
  - `activo` = 1 after edge k.
  - First decrement visible after edge k+DIV, since the prescaler starts at 0 from IDLE.
  - Each later decrement follows every DIV cycles.
- Resume after pause: the remaining prescaler count is preserved. Pause at prescaler p, then resume, gives the next decrement DIV-p cycles after RUN re-entry.
- `pausa` in the same cycle as prescaler == DIV-1: pause wins, no decrement. The prescaler stays at DIV-1, and the decrement fires on the first RUN cycle after resume.
- `carga` or `apagar` during RUN takes effect at the next edge, and no decrement is applied on that edge.
- `reset_total` asserted mid-count: outputs zero immediately (asynchronous) and remain so until release.
- Last decrement to zero: `crono_final` rises on the same edge that zeroes `seg_crono`. `activo` falls on that edge.

## Test plan

DIV = 4 for all scenarios.

- **Reset:** assert `reset_total` mid-RUN → all outputs 0 within the same cycle; after release, `inicio` alone keeps IDLE (`activo` = 0).
- **Load and count:** `carga` with 00/01/01 then `inicio` → `seg_crono` shows 01, then 00, then `min_crono` 00 with `seg_crono` 59, one step per 4 cycles. First step lands exactly 4 cycles after `activo` rises.
- **Borrow chain:** load 01/00/00, run one step → 00/59/59. Load 10/00/00, run one step → 09/59/59.
- **Completion:** load 00/00/02, run → after 8 cycles all zero, `crono_final` = 1, `activo` = 0.
  - `inicio` in DONE has no effect.
  - `apagar` clears `crono_final` next cycle.
- **Pause/resume:** pause 2 cycles into a step, hold 10 cycles → value unchanged. Resume → next decrement 2 cycles after `activo` rises.
  - Pause coincident with prescaler = 3 → no decrement on that edge.
- **Validation and priority:**
  - Load `hora_ini` = 0x24, `min_ini` = 0x5A, `seg_ini` = 0x30 → 00/00/30.
  - `carga` and `inicio` in the same cycle → load wins, state IDLE.
  - `inicio` at 00/00/00 → stays IDLE.
